ctrl_pipe_unit: RTL and testbench

- Next-generation control unit: decodes the ID-stage opcode, then carries the control bundle through ID/EX, EX/MEM and MEM/WB registers with valid bits.
- Adds load-use hazard detection, external stall, branch flush, optional jump/LUI decode and an illegal-opcode counter.
- Sits between the IF/ID register and the datapath stage muxes; each stage reads its control fields directly from this block.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/ctrl_decoder.sv | 62 ++++++
 rtl/ctrl_pipe_unit.sv | 156 +++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the control pipeline.
// The bundle layout is fixed by the packed struct field order below.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int ALU_OP_W = 2;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_PASS  = 2'b11;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: control bundle, source-register usage and illegal flag.
// lui/jal decode only when ENABLE_EXT is nonzero; otherwise they fall into the illegal group.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int ENABLE_EXT = 1
) (
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       illegal
);

    always_comb begin
        ctrl     = CTRL_NOP;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_LOAD: begin
                ctrl     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OP_ADD};
                uses_rs1 = 1'b1;
            end
            OP_IMM: begin
                ctrl     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OP_ADD};
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                ctrl     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALU_OP_ADD};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_REG: begin
                ctrl     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OP_FUNCT};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_OP_SUB};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LUI: begin
                if (ENABLE_EXT != 0) begin
                    ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OP_PASS};
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JAL: begin
                if (ENABLE_EXT != 0) begin
                    ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_OP_ADD};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Control pipeline: decodes the ID opcode and carries controls through ID/EX, EX/MEM, MEM/WB
// with load-use detection, external stall, branch flush and a saturating illegal-opcode counter.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ENABLE_EXT = 1,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ext_stall,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [1:0]            ex_alu_op,
    output logic                  mem_valid,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_jump,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  ex_illegal,
    output logic [CNT_W-1:0]      illegal_cnt
);

    ctrl_t dec_ctrl;
    logic  dec_uses_rs1;
    logic  dec_uses_rs2;
    logic  dec_illegal;

    ctrl_decoder #(
        .ENABLE_EXT(ENABLE_EXT)
    ) u_dec (
        .opcode  (id_opcode),
        .ctrl    (dec_ctrl),
        .uses_rs1(dec_uses_rs1),
        .uses_rs2(dec_uses_rs2),
        .illegal (dec_illegal)
    );

    // ID/EX
    logic                  vld_p0;
    ctrl_t                 ctrl_p0;
    logic [REG_ADDR_W-1:0] rd_p0;
    logic                  illegal_p0;

    // EX/MEM
    logic                  vld_p1;
    logic                  reg_write_p1;
    logic                  mem_to_reg_p1;
    logic                  mem_read_p1;
    logic                  mem_write_p1;
    logic                  jump_p1;
    logic [REG_ADDR_W-1:0] rd_p1;

    // MEM/WB
    logic                  vld_p2;
    logic                  reg_write_p2;
    logic                  mem_to_reg_p2;
    logic                  jump_p2;
    logic [REG_ADDR_W-1:0] rd_p2;

    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             bubble_p0;
    logic             enter_illegal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign load_use = vld_p0 & ctrl_p0.mem_read & (rd_p0 != '0) & id_valid &
                      ((dec_uses_rs1 & (rd_p0 == id_rs1)) | (dec_uses_rs2 & (rd_p0 == id_rs2)));
    assign hazard_stall  = load_use & ~flush & ~ext_stall;
    assign bubble_p0     = flush | load_use | ~id_valid;
    assign enter_illegal = ~bubble_p0 & dec_illegal;

    // Stage boundaries: ID -> EX (p0), EX -> MEM (p1), MEM -> WB (p2); ext_stall freezes all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0        <= 1'b0;
            ctrl_p0       <= CTRL_NOP;
            rd_p0         <= '0;
            illegal_p0    <= 1'b0;
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            jump_p1       <= 1'b0;
            rd_p1         <= '0;
            vld_p2        <= 1'b0;
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= 1'b0;
            jump_p2       <= 1'b0;
            rd_p2         <= '0;
            cnt           <= '0;
        end else if (!ext_stall) begin
            vld_p1        <= vld_p0;
            reg_write_p1  <= ctrl_p0.reg_write;
            mem_to_reg_p1 <= ctrl_p0.mem_to_reg;
            mem_read_p1   <= ctrl_p0.mem_read;
            mem_write_p1  <= ctrl_p0.mem_write;
            jump_p1       <= ctrl_p0.jump;
            rd_p1         <= rd_p0;
            vld_p2        <= vld_p1;
            reg_write_p2  <= reg_write_p1;
            mem_to_reg_p2 <= mem_to_reg_p1;
            jump_p2       <= jump_p1;
            rd_p2         <= rd_p1;
            if (bubble_p0) begin
                vld_p0     <= 1'b0;
                ctrl_p0    <= CTRL_NOP;
                rd_p0      <= '0;
                illegal_p0 <= 1'b0;
            end else begin
                // An illegal opcode decodes to an all-zero bundle and occupies the slot invalid.
                vld_p0     <= ~dec_illegal;
                ctrl_p0    <= dec_ctrl;
                rd_p0      <= dec_illegal ? '0 : id_rd;
                illegal_p0 <= dec_illegal;
            end
            if (enter_illegal) begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    assign ex_valid      = vld_p0;
    assign ex_alu_src    = ctrl_p0.alu_src;
    assign ex_branch     = ctrl_p0.branch;
    assign ex_jump       = ctrl_p0.jump;
    assign ex_alu_op     = ctrl_p0.alu_op;
    assign ex_illegal    = illegal_p0;
    assign mem_valid     = vld_p1;
    assign mem_read      = mem_read_p1;
    assign mem_write     = mem_write_p1;
    assign wb_valid      = vld_p2;
    assign wb_reg_write  = reg_write_p2;
    assign wb_mem_to_reg = mem_to_reg_p2;
    assign wb_jump       = jump_p2;
    assign wb_rd         = rd_p2;
    assign illegal_cnt   = cnt;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: directed scenarios then randomized traffic,
// checked against a slot-level reference model and a write-back queue.
module tb_ctrl_pipe_unit;

    localparam int RW = 5;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [6:0]    id_opcode = '0;
    logic [RW-1:0] id_rd = '0;
    logic [RW-1:0] id_rs1 = '0;
    logic [RW-1:0] id_rs2 = '0;
    logic          ext_stall = 1'b0;
    logic          flush = 1'b0;

    logic          hazard_stall, ex_valid, ex_alu_src, ex_branch, ex_jump;
    logic [1:0]    ex_alu_op;
    logic          mem_valid, mem_read, mem_write;
    logic          wb_valid, wb_reg_write, wb_mem_to_reg, wb_jump;
    logic [RW-1:0] wb_rd;
    logic          ex_illegal;
    logic [CW-1:0] illegal_cnt;

    logic          n_hazard_stall, n_ex_valid, n_ex_alu_src, n_ex_branch, n_ex_jump;
    logic [1:0]    n_ex_alu_op;
    logic          n_mem_valid, n_mem_read, n_mem_write;
    logic          n_wb_valid, n_wb_reg_write, n_wb_mem_to_reg, n_wb_jump;
    logic [RW-1:0] n_wb_rd;
    logic          n_ex_illegal;
    logic [7:0]    n_illegal_cnt;

    ctrl_pipe_unit #(.REG_ADDR_W(RW), .ENABLE_EXT(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ext_stall(ext_stall), .flush(flush),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_jump(wb_jump), .wb_rd(wb_rd), .ex_illegal(ex_illegal), .illegal_cnt(illegal_cnt)
    );

    ctrl_pipe_unit #(.REG_ADDR_W(RW), .ENABLE_EXT(0), .CNT_W(8)) dut_noext (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ext_stall(ext_stall), .flush(flush),
        .hazard_stall(n_hazard_stall), .ex_valid(n_ex_valid), .ex_alu_src(n_ex_alu_src),
        .ex_branch(n_ex_branch), .ex_jump(n_ex_jump), .ex_alu_op(n_ex_alu_op),
        .mem_valid(n_mem_valid), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .wb_valid(n_wb_valid), .wb_reg_write(n_wb_reg_write), .wb_mem_to_reg(n_wb_mem_to_reg),
        .wb_jump(n_wb_jump), .wb_rd(n_wb_rd), .ex_illegal(n_ex_illegal), .illegal_cnt(n_illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic valid, rw, m2r, mr, mw, br, jp, asrc;
        logic [1:0] aop;
        logic [RW-1:0] rd;
        logic ill;
    } slot_t;

    typedef struct packed {
        logic rw, m2r, jp;
        logic [RW-1:0] rd;
    } wb_t;

    slot_t m_ex = '0;
    slot_t m_mem = '0;
    int    m_cnt = 0;
    wb_t   sbq[$];
    int    checks = 0;
    int    errors = 0;
    logic  stall_q = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec decode table: {reg_write, mem_to_reg, mem_read, mem_write, branch, jump, alu_src, alu_op}.
    function automatic slot_t ref_decode(input logic [6:0] op, input logic [RW-1:0] rd);
        slot_t s;
        logic [8:0] f;
        s = '0;
        f = 9'b0;
        case (op)
            7'b0000011: f = 9'b111000100;
            7'b0010011: f = 9'b100000100;
            7'b0100011: f = 9'b000100100;
            7'b0110011: f = 9'b100000010;
            7'b1100011: f = 9'b000010001;
            7'b0110111: f = 9'b100000111;
            7'b1101111: f = 9'b100001100;
            default:    s.ill = 1'b1;
        endcase
        if (!s.ill) begin
            s.valid = 1'b1;
            s.rd    = rd;
            {s.rw, s.m2r, s.mr, s.mw, s.br, s.jp, s.asrc, s.aop} = f;
        end
        return s;
    endfunction

    function automatic logic uses1(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b1100011};
    endfunction

    function automatic logic uses2(input logic [6:0] op);
        return op inside {7'b0100011, 7'b0110011, 7'b1100011};
    endfunction

    function automatic logic [63:0] all_out();
        return 64'({hazard_stall, ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_illegal,
                    mem_valid, mem_read, mem_write, wb_valid, wb_reg_write, wb_mem_to_reg,
                    wb_jump, wb_rd, illegal_cnt});
    endfunction

    // One clock: drive inputs, check the current stage outputs at negedge, advance the model.
    task automatic step(input logic v, input logic [6:0] op, input logic [RW-1:0] rd,
                        input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic st, input logic fl);
        logic lu;
        slot_t d;
        id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        ext_stall = st; flush = fl;
        lu = m_ex.valid && m_ex.mr && (m_ex.rd != 0) && v &&
             ((uses1(op) && m_ex.rd == rs1) || (uses2(op) && m_ex.rd == rs2));
        @(negedge clk);
        check("hazard_stall", 64'(hazard_stall), 64'(lu && !fl && !st));
        check("ex_stage", 64'({ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_illegal}),
              64'({m_ex.valid, m_ex.asrc, m_ex.br, m_ex.jp, m_ex.aop, m_ex.ill}));
        check("mem_stage", 64'({mem_valid, mem_read, mem_write}),
              64'({m_mem.valid, m_mem.mr, m_mem.mw}));
        check("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
        if (!st) begin
            m_mem = m_ex;
            if (fl || lu || !v) begin
                m_ex = '0;
            end else begin
                d = ref_decode(op, rd);
                m_ex = d;
                if (d.ill) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    sbq.push_back('{d.rw, d.m2r, d.jp, rd});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'd0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_wb_now(input string name, input logic v, input logic rw,
                                input logic m2r, input logic [RW-1:0] rd);
        check(name, 64'({wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd}), 64'({v, rw, m2r, rd}));
    endtask

    always @(posedge clk) stall_q <= ext_stall;

    // Monitor: every fresh write-back slot pops one expected entry.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !stall_q && wb_valid) begin
                if (sbq.size() == 0) begin
                    check("wb_unexpected", 64'(wb_valid), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    check("wb_slot", 64'({wb_reg_write, wb_mem_to_reg, wb_jump, wb_rd}),
                          64'({e.rw, e.m2r, e.jp, e.rd}));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    localparam logic [6:0] LW = 7'b0000011, ADDI = 7'b0010011, SW = 7'b0100011, ADD = 7'b0110011;
    localparam logic [6:0] BEQ = 7'b1100011, LUI = 7'b0110111, JAL = 7'b1101111, BAD = 7'b1111111;

    initial begin
        logic [6:0] ops [9];
        logic last_st, last_fl, st, fl;
        int exp_cnt [6];
        ops = '{LW, ADDI, SW, ADD, BEQ, LUI, JAL, BAD, 7'd0};
        exp_cnt = '{1, 2, 3, 3, 3, 3};

        #2;
        check("reset_outputs", all_out(), 64'(0));
        check("reset_noext_cnt", 64'(n_illegal_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lui/jal: legal in the main unit, illegal in the ENABLE_EXT=0 unit.
        step(1'b1, LUI, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        check("noext_lui", 64'({n_ex_valid, n_ex_illegal, n_illegal_cnt}), 64'({1'b0, 1'b1, 8'd1}));
        step(1'b1, JAL, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        check("noext_jal", 64'({n_ex_valid, n_ex_illegal, n_illegal_cnt}), 64'({1'b0, 1'b1, 8'd2}));
        idle(1);
        check("noext_clear", 64'({n_ex_illegal, n_illegal_cnt}), 64'({1'b0, 8'd2}));
        idle(2);

        // Straight line: lw x5 then add x6,x1,x2.
        step(1'b1, LW, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
        step(1'b1, ADD, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0);
        idle(1);
        check_wb_now("wb_lw_c3", 1'b1, 1'b1, 1'b1, 5'd5);
        idle(1);
        check_wb_now("wb_add_c4", 1'b1, 1'b1, 1'b0, 5'd6);
        idle(2);

        // Load-use, then the rd=0 variant.
        step(1'b1, LW, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
        step(1'b1, ADD, 5'd7, 5'd5, 5'd2, 1'b0, 1'b0);
        step(1'b1, ADD, 5'd7, 5'd5, 5'd2, 1'b0, 1'b0);
        idle(2);
        check_wb_now("wb_add_after_stall", 1'b1, 1'b1, 1'b0, 5'd7);
        step(1'b1, LW, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0);
        step(1'b1, ADD, 5'd7, 5'd0, 5'd2, 1'b0, 1'b0);
        idle(3);

        // Flush coinciding with a load-use candidate.
        step(1'b1, LW, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
        step(1'b1, ADD, 5'd7, 5'd5, 5'd1, 1'b0, 1'b1);
        idle(3);

        // ext_stall for 3 cycles with flush held, then flush applies.
        step(1'b1, LW, 5'd3, 5'd1, 5'd0, 1'b0, 1'b0);
        step(1'b1, ADDI, 5'd4, 5'd2, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, ADD, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1);
        step(1'b1, ADD, 5'd8, 5'd1, 5'd2, 1'b0, 1'b1);
        idle(3);

        // Reset mid-stream discards in-flight controls immediately.
        step(1'b1, LW, 5'd9, 5'd1, 5'd0, 1'b0, 1'b0);
        step(1'b1, ADDI, 5'd10, 5'd2, 5'd0, 1'b0, 1'b0);
        step(1'b1, SW, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0);
        rst_n = 1'b0;
        id_valid = 1'b0;
        #1;
        check("reset_midstream", all_out(), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ex = '0; m_mem = '0; m_cnt = 0;
        sbq.delete();
        step(1'b1, LW, 5'd9, 5'd1, 5'd0, 1'b0, 1'b0);
        idle(1);
        check("wb_empty_after_reset", 64'(wb_valid), 64'(0));
        idle(1);
        check_wb_now("wb_first_after_reset", 1'b1, 1'b1, 1'b1, 5'd9);

        // Illegal opcodes with a 2-bit saturating counter.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, BAD, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0);
            check("illegal_pulse", 64'({ex_illegal, ex_valid, illegal_cnt}),
                  64'({1'b1, 1'b0, 2'(exp_cnt[i])}));
        end
        idle(2);

        // Randomized traffic.
        last_st = 1'b0;
        last_fl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            int k;
            k  = $urandom_range(0, 8);
            op = (k == 8) ? 7'($urandom) : ops[k];
            st = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 9) == 0) || (last_st && last_fl);
            step(1'($urandom_range(0, 4) != 0), op, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), st, fl);
            last_st = st;
            last_fl = fl;
        end
        idle(5);
        check("scoreboard_drained", 64'(sbq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
